// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux -- registered C-to-1 channel multiplexer with valid/ready handshake.
//
// Picks one of C producer channels, either by an explicit select (mode = 0)
// or by round-robin arbitration (mode = 1). The winning beat goes through a
// single output register stage toward one consumer.
//
// Parameters:
//   N   data width per channel
//   C   channel count (2..64, any value, not only powers of two)
//   SW  channel index width, derived from C; do not override
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   mode       0 = fixed select by s, 1 = round-robin
//   s          channel select, only used when mode = 0
//   in_valid   per-channel valid
//   in_data    packed channel data, channel k at [k*N +: N]
//   in_ready   per-channel ready, one-hot or zero
//   out_valid  output register holds a beat
//   out_data   registered data of the held beat
//   out_ch     index of the channel that supplied out_data
//   out_ready  consumer accepts the beat when out_valid & out_ready
// -----------------------------------------------------------------------------
module arb_mux #(
  parameter int N  = 32,
  parameter int C  = 16,
  parameter int SW = $clog2(C)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  input  logic [C-1:0]   in_valid,
  input  logic [C*N-1:0] in_data,
  output logic [C-1:0]   in_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  // One extra bit so that (last + i) never overflows before the wrap.
  // The largest sum is 2C-1, which always fits because C <= 2**SW.
  localparam int            SW1      = SW + 1;
  localparam logic [SW:0]   C_W      = SW1'(C);
  localparam logic [SW-1:0] LAST_RST = SW'(C - 1);
  localparam logic [C-1:0]  ONE_HOT0 = C'(1);

  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic [SW-1:0] last_q,      last_d;

  logic          load;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic [SW:0]   rr_cand;
  logic          fx_found;
  logic          grant_found;
  logic [SW-1:0] grant_idx;
  logic          xfer;

  // The register can take a new beat when it is empty or being drained now.
  // out_ready reaches in_ready through this term on purpose (no skid buffer).
  assign load = ~out_valid_q | out_ready;

  // Round-robin search: candidates last+1, ..., C-1, 0, ..., last.
  // The pointer itself is visited last, so the previous winner has lowest
  // priority.
  always_comb begin : rr_search
    // NOTE: every signal written here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int i = 1; i <= C; i++) begin
      rr_cand = {1'b0, last_q} + SW1'(i);
      if (rr_cand >= C_W) begin
        rr_cand = rr_cand - C_W;
      end
      if (!rr_found && in_valid[rr_cand[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand[SW-1:0];
      end
    end
  end

  // Fixed select: a select past the last channel never grants. This can only
  // happen when C is not a power of two.
  assign fx_found = ({1'b0, s} < C_W) && in_valid[s];

  assign grant_found = mode ? rr_found : fx_found;
  assign grant_idx   = mode ? rr_idx   : s;

  // Nothing is accepted during reset, because the register is cleared anyway.
  assign xfer     = load & grant_found & ~rst;
  assign in_ready = xfer ? (ONE_HOT0 << grant_idx) : '0;

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (load) begin
      // An empty load clears valid but keeps the stale data and channel.
      out_valid_d = grant_found;
      if (grant_found) begin
        out_data_d = in_data[int'(grant_idx) * N +: N];
        out_ch_d   = grant_idx;
        // Fixed-select transfers must not disturb the round-robin pointer.
        if (mode) begin
          last_d = grant_idx;
        end
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= LAST_RST;   // channel 0 has first priority after reset
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
